// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over an 8N1 UART line and writes it, one 32-bit
//   little-endian word at a time, into an instruction memory. A word equal to
//   END_WORD terminates the load instead of being written.
//
// Parameters
//   ADDR_W    width of the word address driven on addr_o
//   END_WORD  end-of-program marker word
//
// Ports
//   clk_i    single clock
//   rst_ni   asynchronous active-low reset
//   en_i     loader enable; low holds the block idle and cleared
//   rx_i     UART serial input (asynchronous, idle high)
//   cbp_i    clocks per bit, sampled at each start bit (4..65535)
//   we_o     write request to instruction memory
//   addr_o   word address of the pending write
//   wdata_o  data of the pending write
//   ready_i  memory accepts the write this cycle
//   done_o   end-of-program word received
//   busy_o   byte reception in progress or write pending
//   err_o    sticky framing / overrun error
module uart_prog_loader #(
   parameter int unsigned ADDR_W   = 14,
   parameter logic [31:0] END_WORD = 32'h0000_0FFF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              rx_i,
   input  logic [15:0]       cbp_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [31:0]       wdata_o,
   input  logic              ready_i,
   output logic              done_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic              rx_s1, rx_s2;
   logic [1:0]        prime;
   logic              armed;
   logic [1:0]        state;
   logic [15:0]       cbp_q;
   logic [15:0]       cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        rx_sr;
   logic              stop_wait;
   logic [1:0]        byte_cnt;
   logic [31:0]       word_sr;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [31:0]       wdata_q;
   logic              done_q;
   logic              err_q;

   logic [15:0]       half_m1;
   logic              tick_full;
   logic              byte_vld;
   logic              stop_bad;
   logic [31:0]       new_word;

   // Two-flop synchroniser; idle-high reset value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx_i;
         rx_s2 <= rx_s1;
      end
   end

   // rx_s2 only carries real line state two clocks after reset release
   // (before that it is the reset value), so arming waits on prime[1].
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prime <= '0;
         armed <= 1'b0;
      end else begin
         prime <= {prime[0], 1'b1};
         armed <= armed | (prime[1] & rx_s2);
      end
   end

   always_comb begin
      half_m1   = {1'b0, cbp_q[15:1]} - 16'd1;
      tick_full = (cnt == cbp_q - 16'd1);
      byte_vld  = (state == S_STOP) && !stop_wait && tick_full && rx_s2;
      stop_bad  = (state == S_STOP) && !stop_wait && tick_full && !rx_s2;
      new_word  = {rx_sr, word_sr[31:8]};
   end

   // Receive FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= S_IDLE;
         cbp_q     <= '0;
         cnt       <= '0;
         bit_cnt   <= '0;
         rx_sr     <= '0;
         stop_wait <= 1'b0;
      end else if (!en_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         stop_wait <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rx_s2 && armed && !done_q) begin
                  state <= S_START;
                  cbp_q <= cbp_i;
                  // The detection cycle already counts toward the half-bit.
                  cnt   <= 16'd1;
               end
            end
            S_START: begin
               if (cnt == half_m1) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (tick_full) begin
                  cnt     <= '0;
                  rx_sr   <= {rx_s2, rx_sr[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= S_STOP;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               if (stop_wait) begin
                  // Bad stop bit: stay here until the line returns high.
                  if (rx_s2) begin
                     stop_wait <= 1'b0;
                     state     <= S_IDLE;
                  end
               end else if (tick_full) begin
                  cnt <= '0;
                  if (rx_s2) begin
                     state <= S_IDLE;
                  end else begin
                     stop_wait <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // Word assembly and memory write port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         byte_cnt <= '0;
         word_sr  <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else if (!en_i) begin
         byte_cnt <= '0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (we_q && ready_i) begin
            we_q   <= 1'b0;
            addr_q <= addr_q + ADDR_W'(1);
         end
         if (stop_bad) begin
            err_q <= 1'b1;
         end
         if (byte_vld && !done_q) begin
            byte_cnt <= byte_cnt + 2'd1;
            word_sr  <= new_word;
            if (byte_cnt == 2'd3) begin
               if (new_word == END_WORD) begin
                  done_q <= 1'b1;
               end else if (we_q) begin
                  // Overrun: the pending write is left untouched.
                  err_q <= 1'b1;
               end else begin
                  we_q    <= 1'b1;
                  wdata_q <= new_word;
               end
            end
         end
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign done_o  = done_q;
   assign err_o   = err_q;
   assign busy_o  = (state != S_IDLE) | we_q;

endmodule
